// File: rtl/gpio_seq_monitor.sv
// GPIO blink-pulse counter and checkbits sequence checker giving one pass/fail/timeout verdict.
// Define GPIO_MON_WATCHDOG_EN to turn the run timer into an inactivity watchdog.
module gpio_seq_monitor #(
  parameter int WIDTH          = 16,
  parameter int N_PULSES       = 10,
  parameter int EXP_DEPTH      = 8,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             gpio_in,
  input  logic [WIDTH-1:0] checkbits_in,
  input  logic             exp_valid,
  input  logic [WIDTH-1:0] exp_value,
  output logic             exp_ready,
  output logic [7:0]       pulse_count,
  output logic [7:0]       match_count,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code
);

  localparam int AW = $clog2(EXP_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

`ifdef GPIO_MON_WATCHDOG_EN
  localparam bit WATCHDOG_EN = 1'b1;
`else
  localparam bit WATCHDOG_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t           state_q, state_d;
  logic             gpio_s1_q, gpio_s2_q, gpio_prev_q;
  logic [WIDTH-1:0] cb_s1_q, cb_s2_q, cb_hold_q, last_stable_q, last_stable_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic             enable_prev_q;
  logic [31:0]      timer_q, timer_d;
  logic [7:0]       pulse_count_q, pulse_count_d;
  logic [7:0]       match_count_q, match_count_d;
  logic [1:0]       fail_code_q, fail_code_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [EXP_DEPTH];
  logic [WIDTH-1:0] mem_d [EXP_DEPTH];

  logic             fall, new_value, fifo_empty, fifo_full, push, pop;
  logic             pulse_inc, match_hit, mismatch, pass_hit;
  logic [WIDTH-1:0] head;

  // Stability filter: the run length includes the current cycle, so a value
  // strobes on its STABLE_CYCLES-th consecutive synchronised cycle.
  always_comb begin
    fall          = gpio_prev_q & ~gpio_s2_q;
    hold_cnt_d    = 8'd1;
    if (cb_s2_q == cb_hold_q)
      hold_cnt_d = (hold_cnt_q == 8'hFF) ? 8'hFF : hold_cnt_q + 8'd1;
    new_value     = (hold_cnt_d >= 8'(STABLE_CYCLES)) && (cb_s2_q != last_stable_q);
    last_stable_d = new_value ? cb_s2_q : last_stable_q;
  end

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head       = mem_q[rd_ptr_q[AW-1:0]];
    push       = exp_valid & ~fifo_full;

    state_d       = state_q;
    timer_d       = timer_q;
    pulse_count_d = pulse_count_q;
    match_count_d = match_count_q;
    fail_code_d   = fail_code_q;
    pop           = 1'b0;
    pulse_inc     = 1'b0;
    match_hit     = 1'b0;
    mismatch      = 1'b0;
    pass_hit      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && !enable_prev_q) begin
          state_d       = S_RUN;
          timer_d       = '0;
          pulse_count_d = '0;
          match_count_d = '0;
        end
      end
      S_RUN: begin
        timer_d   = timer_q + 32'd1;
        pulse_inc = fall && (pulse_count_q != 8'hFF);
        match_hit = new_value && !fifo_empty && (cb_s2_q == head);
        mismatch  = new_value && !fifo_empty && (cb_s2_q != head);
        if (pulse_inc) pulse_count_d = pulse_count_q + 8'd1;
        if (match_hit) begin
          pop = 1'b1;
          if (match_count_q != 8'hFF) match_count_d = match_count_q + 8'd1;
        end
        if (WATCHDOG_EN && (pulse_inc || match_hit)) timer_d = '0;
      end
      default: ;
    endcase

    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;

    // Pass looks at post-update counts so a final pop and final pulse can coincide.
    if (state_q == S_RUN) begin
      pass_hit = (pulse_count_d == 8'(N_PULSES)) && (wr_ptr_d == rd_ptr_d);
      if (mismatch) begin
        state_d     = S_FAIL;
        fail_code_d = 2'b10;
      end else if (pass_hit) begin
        state_d = S_PASS;
      end else if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
        state_d     = S_FAIL;
        fail_code_d = 2'b01;
      end else if (!enable) begin
        state_d = S_IDLE;
      end
    end

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q[AW-1:0]] = exp_value;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      gpio_s1_q     <= 1'b0;
      gpio_s2_q     <= 1'b0;
      gpio_prev_q   <= 1'b0;
      cb_s1_q       <= '0;
      cb_s2_q       <= '0;
      cb_hold_q     <= '0;
      hold_cnt_q    <= '0;
      last_stable_q <= '0;
      enable_prev_q <= 1'b0;
      timer_q       <= '0;
      pulse_count_q <= '0;
      match_count_q <= '0;
      fail_code_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < EXP_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      gpio_s1_q     <= gpio_in;
      gpio_s2_q     <= gpio_s1_q;
      gpio_prev_q   <= gpio_s2_q;
      cb_s1_q       <= checkbits_in;
      cb_s2_q       <= cb_s1_q;
      cb_hold_q     <= cb_s2_q;
      hold_cnt_q    <= hold_cnt_d;
      last_stable_q <= last_stable_d;
      enable_prev_q <= enable;
      timer_q       <= timer_d;
      pulse_count_q <= pulse_count_d;
      match_count_q <= match_count_d;
      fail_code_q   <= fail_code_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_q         <= mem_d;
    end
  end

  assign exp_ready   = ~fifo_full;
  assign pulse_count = pulse_count_q;
  assign match_count = match_count_q;
  assign pass        = (state_q == S_PASS);
  assign fail        = (state_q == S_FAIL);
  assign done        = pass | fail;
  assign fail_code   = fail_code_q;

endmodule

// File: tb/tb_gpio_seq_monitor.sv
// Directed self-checking bench for gpio_seq_monitor; expectations are queued
// as stimulus is applied and popped/compared when outputs are sampled.
module tb_gpio_seq_monitor;

   localparam int WIDTH          = 16;
   localparam int N_PULSES       = 10;
   localparam int EXP_DEPTH      = 8;
   localparam int STABLE_CYCLES  = 4;
   localparam int TIMEOUT_CYCLES = 1000;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b0;
   logic             gpio_in = 1'b0;
   logic [WIDTH-1:0] checkbits_in = '0;
   logic             exp_valid = 1'b0;
   logic [WIDTH-1:0] exp_value = '0;
   logic             exp_ready;
   logic [7:0]       pulse_count;
   logic [7:0]       match_count;
   logic             done;
   logic             pass;
   logic             fail;
   logic [1:0]       fail_code;

   // Device under test with a short timeout so the timeout case stays quick
   gpio_seq_monitor #(
      .WIDTH(WIDTH), .N_PULSES(N_PULSES), .EXP_DEPTH(EXP_DEPTH),
      .STABLE_CYCLES(STABLE_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .gpio_in(gpio_in),
      .checkbits_in(checkbits_in), .exp_valid(exp_valid), .exp_value(exp_value),
      .exp_ready(exp_ready), .pulse_count(pulse_count), .match_count(match_count),
      .done(done), .pass(pass), .fail(fail), .fail_code(fail_code)
   );

   // Free-running 10 ns clock
   always #5 clock = ~clock;

   // Hard stop in case something hangs
   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout simulation exceeded time limit");
      $fatal(1, "[TB] global timeout");
   end

   typedef enum int {SIG_PULSE, SIG_MATCH, SIG_DONE, SIG_PASS, SIG_FAIL, SIG_CODE, SIG_READY} sig_e;
   typedef struct {
      string       tag;
      sig_e        sel;
      logic [31:0] value;
   } exp_t;

   exp_t sbQueue[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   lastPulseCyc = 0;
   logic [7:0] prevPulse = 8'd0;

   // Pick the DUT output that a queued expectation refers to
   function automatic logic [31:0] observe(sig_e sel);
      case (sel)
         SIG_PULSE: return {24'd0, pulse_count};
         SIG_MATCH: return {24'd0, match_count};
         SIG_DONE:  return {31'd0, done};
         SIG_PASS:  return {31'd0, pass};
         SIG_FAIL:  return {31'd0, fail};
         SIG_CODE:  return {30'd0, fail_code};
         default:   return {31'd0, exp_ready};
      endcase
   endfunction

   // Single comparison point: counts every check and every failure
   task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic expectOut(input string tag, input sig_e sel, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.value = v;
      sbQueue.push_back(e);
   endtask

   // Drain the scoreboard against the outputs as sampled right now
   task automatic checkOutput();
      exp_t e;
      while (sbQueue.size() > 0) begin
         e = sbQueue.pop_front();
         compare(e.tag, observe(e.sel), e.value);
      end
   endtask

   // Advance on falling edges so outputs are sampled away from the active edge
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         cyc++;
         if (pulse_count != prevPulse) lastPulseCyc = cyc;
         prevPulse = pulse_count;
      end
   endtask

   task automatic applyStimulus(input logic [WIDTH-1:0] value, input int n);
      checkbits_in = value;
      tick(n);
   endtask

   task automatic pulseGpio(input int hi, input int lo);
      gpio_in = 1'b1;
      tick(hi);
      gpio_in = 1'b0;
      tick(lo);
   endtask

   task automatic pushValue(input logic [WIDTH-1:0] value);
      exp_valid = 1'b1;
      exp_value = value;
      tick(1);
      exp_valid = 1'b0;
   endtask

   task automatic doReset();
      enable = 1'b0;
      exp_valid = 1'b0;
      gpio_in = 1'b0;
      checkbits_in = '0;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   task automatic expectCleared(input string tag);
      expectOut({tag, "_pulse"}, SIG_PULSE, 0);
      expectOut({tag, "_match"}, SIG_MATCH, 0);
      expectOut({tag, "_done"},  SIG_DONE,  0);
      expectOut({tag, "_pass"},  SIG_PASS,  0);
      expectOut({tag, "_fail"},  SIG_FAIL,  0);
      expectOut({tag, "_code"},  SIG_CODE,  0);
      expectOut({tag, "_ready"}, SIG_READY, 1);
   endtask

   // Directed sequence of all scenarios
   initial begin
      logic [15:0] seqVals [3];
      int cycEnable;
      int latency;
      seqVals[0] = 16'h00A5;
      seqVals[1] = 16'h0F0F;
      seqVals[2] = 16'h1234;

      // Reset state
      tick(1);
      doReset();
      expectCleared("rst");
      checkOutput();

      // Preloaded sequence interleaved with ten pulses -> pass
      for (int i = 0; i < 3; i++) pushValue(seqVals[i]);
      enable = 1'b1;
      tick(2);
      for (int i = 0; i < N_PULSES; i++) begin
         if (i < 3) begin
            applyStimulus(seqVals[i], 8);
            expectOut($sformatf("seq_match%0d", i), SIG_MATCH, i + 1);
         end
         pulseGpio(5, 5);
         expectOut($sformatf("seq_pulse%0d", i), SIG_PULSE, i + 1);
         if (i < N_PULSES - 1) expectOut($sformatf("seq_nopass%0d", i), SIG_PASS, 0);
         checkOutput();
      end
      expectOut("seq_pass", SIG_PASS, 1);
      expectOut("seq_done", SIG_DONE, 1);
      expectOut("seq_fail", SIG_FAIL, 0);
      expectOut("seq_code", SIG_CODE, 0);
      expectOut("seq_match_final", SIG_MATCH, 3);
      checkOutput();

      // Mismatch -> fail code 10, later pulses ignored
      doReset();
      pushValue(16'h00A5);
      enable = 1'b1;
      tick(2);
      applyStimulus(16'h00A6, STABLE_CYCLES + 4);
      expectOut("mis_fail", SIG_FAIL, 1);
      expectOut("mis_code", SIG_CODE, 2);
      expectOut("mis_pass", SIG_PASS, 0);
      expectOut("mis_match", SIG_MATCH, 0);
      checkOutput();
      for (int i = 0; i < 3; i++) pulseGpio(5, 5);
      expectOut("mis_pulse_ignored", SIG_PULSE, 0);
      expectOut("mis_sticky", SIG_FAIL, 1);
      expectOut("mis_code_sticky", SIG_CODE, 2);
      checkOutput();

      // Short glitch must not strobe; a stable value then matches; enable low holds counts
      doReset();
      pushValue(16'h0002);
      enable = 1'b1;
      tick(2);
      applyStimulus(16'h0001, 2);
      applyStimulus(16'h0000, 10);
      expectOut("glitch_match", SIG_MATCH, 0);
      expectOut("glitch_fail", SIG_FAIL, 0);
      checkOutput();
      applyStimulus(16'h0002, 8);
      expectOut("glitch_good_match", SIG_MATCH, 1);
      expectOut("glitch_good_fail", SIG_FAIL, 0);
      checkOutput();
      enable = 1'b0;
      tick(3);
      expectOut("idle_match_held", SIG_MATCH, 1);
      expectOut("idle_done", SIG_DONE, 0);
      checkOutput();

      // Timeout after three pulses
      doReset();
      enable = 1'b1;
      cycEnable = cyc;
      for (int i = 0; i < 3; i++) pulseGpio(5, 5);
      while (!fail && (cyc - cycEnable) < 3 * TIMEOUT_CYCLES) tick(1);
`ifdef GPIO_MON_WATCHDOG_EN
      latency = cyc - lastPulseCyc;
`else
      latency = cyc - cycEnable - 1;
`endif
      compare("to_latency", latency, TIMEOUT_CYCLES);
      expectOut("to_fail", SIG_FAIL, 1);
      expectOut("to_code", SIG_CODE, 1);
      expectOut("to_pulse", SIG_PULSE, 3);
      checkOutput();

      // Reset mid-run clears everything including the FIFO
      doReset();
      pushValue(16'h0BAD);
      enable = 1'b1;
      tick(2);
      for (int i = 0; i < 5; i++) pulseGpio(5, 5);
      expectOut("mid_pulse5", SIG_PULSE, 5);
      checkOutput();
      reset = 1'b1;
      enable = 1'b0;
      tick(1);
      expectCleared("mid_rst");
      checkOutput();
      reset = 1'b0;
      tick(2);
      enable = 1'b1;
      tick(2);
      pulseGpio(5, 5);
      expectOut("restart_pulse1", SIG_PULSE, 1);
      checkOutput();
      for (int i = 1; i < N_PULSES; i++) pulseGpio(5, 5);
      expectOut("restart_pass", SIG_PASS, 1);
      expectOut("restart_pulse", SIG_PULSE, N_PULSES);
      checkOutput();

      // FIFO full handshake: ninth push waits for a pop
      doReset();
      exp_valid = 1'b1;
      for (int i = 0; i < EXP_DEPTH; i++) begin
         exp_value = 16'h0100 + 16'(i);
         tick(1);
      end
      expectOut("fifo_full_ready", SIG_READY, 0);
      checkOutput();
      exp_value = 16'h0109;
      tick(3);
      expectOut("fifo_still_full", SIG_READY, 0);
      checkOutput();
      enable = 1'b1;
      tick(1);
      applyStimulus(16'h0100, 8);
      expectOut("fifo_pop_match", SIG_MATCH, 1);
      expectOut("fifo_refilled", SIG_READY, 0);
      checkOutput();
      exp_valid = 1'b0;
      for (int i = 1; i < EXP_DEPTH; i++) applyStimulus(16'h0100 + 16'(i), 8);
      applyStimulus(16'h0109, 8);
      expectOut("fifo_all_matched", SIG_MATCH, EXP_DEPTH + 1);
      expectOut("fifo_empty_ready", SIG_READY, 1);
      expectOut("fifo_no_fail", SIG_FAIL, 0);
      checkOutput();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
